// File: rtl/prog_loader.sv
// Byte-serial program loader: parses a length-prefixed, XOR-checksummed image,
// writes big-endian words into instruction memory and releases the core once verified.
module prog_loader #(
  parameter logic [15:0] BASE_ADDR = 16'h0000,
  parameter logic [15:0] MAX_WORDS = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] im_addr,
  output logic [31:0] im_data,
  output logic        im_we,
  output logic        cpu_rst_f,
  output logic        done,
  output logic        err,
  output logic [15:0] word_cnt
);

  localparam int unsigned BW = 8;
  localparam int unsigned AW = 16;
  localparam int unsigned DW = 32;

  typedef enum logic [2:0] {
    S_HDR_HI = 3'd0,
    S_HDR_LO = 3'd1,
    S_DATA   = 3'd2,
    S_CHK    = 3'd3,
    S_DONE   = 3'd4,
    S_ERR    = 3'd5
  } state_e;

  state_e        state_q;
  logic          in_ready_q;
  logic          im_we_q;
  logic [AW-1:0] im_addr_q;
  logic [DW-1:0] im_data_q;
  logic          cpu_rst_f_q;
  logic          done_q;
  logic          err_q;
  logic [AW-1:0] word_cnt_q;
  logic [AW-1:0] len_q;
  logic [BW-1:0] csum_q;
  logic [1:0]    byte_idx_q;
  logic [DW-BW-1:0] asm_q;

  logic          xfer;
  logic [AW-1:0] len_d;
  logic [AW-1:0] word_cnt_d;
  logic          len_too_big;

  // Handshake and derived header/counter values
  always_comb begin
    xfer        = in_valid && in_ready_q;
    len_d       = {len_q[AW-1:BW], in_data};
    word_cnt_d  = word_cnt_q + AW'(1);
    len_too_big = ({1'b0, len_d} > {1'b0, MAX_WORDS});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_HDR_HI;
      in_ready_q  <= 1'b0;
      im_we_q     <= 1'b0;
      im_addr_q   <= BASE_ADDR;
      im_data_q   <= '0;
      cpu_rst_f_q <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      word_cnt_q  <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      byte_idx_q  <= '0;
      asm_q       <= '0;
    end else begin
      im_we_q <= 1'b0;
      case (state_q)
        S_HDR_HI: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            len_q[AW-1:BW] <= in_data;
            csum_q         <= csum_q ^ in_data;
            state_q        <= S_HDR_LO;
          end
        end
        S_HDR_LO: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            len_q[BW-1:0] <= in_data;
            csum_q        <= csum_q ^ in_data;
            byte_idx_q    <= '0;
            if (len_too_big) begin
              state_q    <= S_ERR;
              in_ready_q <= 1'b0;
              err_q      <= 1'b1;
            end else if (len_d == '0) begin
              state_q <= S_CHK;
            end else begin
              state_q <= S_DATA;
            end
          end
        end
        S_DATA: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            asm_q      <= {asm_q[DW-2*BW-1:0], in_data};
            csum_q     <= csum_q ^ in_data;
            byte_idx_q <= byte_idx_q + 2'd1;
            // Fourth byte completes a word: issue the write pulse next cycle
            if (byte_idx_q == 2'd3) begin
              im_data_q  <= {asm_q, in_data};
              im_addr_q  <= BASE_ADDR + word_cnt_q;
              im_we_q    <= 1'b1;
              word_cnt_q <= word_cnt_d;
              if (word_cnt_d == len_q) begin
                state_q <= S_CHK;
              end
            end
          end
        end
        S_CHK: begin
          in_ready_q <= 1'b1;
          if (xfer) begin
            in_ready_q <= 1'b0;
            if (in_data == csum_q) begin
              state_q     <= S_DONE;
              done_q      <= 1'b1;
              cpu_rst_f_q <= 1'b1;
            end else begin
              state_q <= S_ERR;
              err_q   <= 1'b1;
            end
          end
        end
        S_DONE: begin
          in_ready_q <= 1'b0;
        end
        S_ERR: begin
          in_ready_q <= 1'b0;
        end
        default: begin
          state_q    <= S_ERR;
          in_ready_q <= 1'b0;
          err_q      <= 1'b1;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign im_we     = im_we_q;
  assign im_addr   = im_addr_q;
  assign im_data   = im_data_q;
  assign cpu_rst_f = cpu_rst_f_q;
  assign done      = done_q;
  assign err       = err_q;
  assign word_cnt  = word_cnt_q;

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: a default instance and a small one (MAX_WORDS=4,
// BASE_ADDR=FFFF for address wrap) share the byte stream; writes go through a scoreboard.
module tb_prog_loader;

  typedef struct packed {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;

  logic        in_ready_m, im_we_m, cpu_rst_f_m, done_m, err_m;
  logic [15:0] im_addr_m, word_cnt_m;
  logic [31:0] im_data_m;
  logic        in_ready_s, im_we_s, cpu_rst_f_s, done_s, err_s;
  logic [15:0] im_addr_s, word_cnt_s;
  logic [31:0] im_data_s;

  int   total = 0;
  int   bad = 0;
  int   nw_m = 0;
  int   nw_s = 0;
  wr_t  q_m[$];
  wr_t  q_s[$];
  wr_t  em, es;
  logic [7:0] stim[$];

  prog_loader dut_m (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_m), .im_addr(im_addr_m), .im_data(im_data_m), .im_we(im_we_m),
    .cpu_rst_f(cpu_rst_f_m), .done(done_m), .err(err_m), .word_cnt(word_cnt_m)
  );

  prog_loader #(.BASE_ADDR(16'hFFFF), .MAX_WORDS(16'd4)) dut_s (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready_s), .im_addr(im_addr_s), .im_data(im_data_s), .im_we(im_we_s),
    .cpu_rst_f(cpu_rst_f_s), .done(done_s), .err(err_s), .word_cnt(word_cnt_s)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Write monitor: every im_we pulse must match the head of its scoreboard queue
  always @(negedge clk) begin
    if (im_we_m === 1'b1) begin
      nw_m++;
      check("m_wr_expected", 32'(q_m.size() > 0), 32'd1);
      check("m_wr_before_done", 32'(done_m), 32'd0);
      if (q_m.size() > 0) begin
        em = q_m.pop_front();
        check("m_wr_addr", 32'(im_addr_m), 32'(em.a));
        check("m_wr_data", im_data_m, em.d);
      end
    end
    if (im_we_s === 1'b1) begin
      nw_s++;
      check("s_wr_expected", 32'(q_s.size() > 0), 32'd1);
      check("s_wr_before_done", 32'(done_s), 32'd0);
      if (q_s.size() > 0) begin
        es = q_s.pop_front();
        check("s_wr_addr", 32'(im_addr_s), 32'(es.a));
        check("s_wr_data", im_data_s, es.d);
      end
    end
  end

  task automatic push_wr(input bit sel_s, input logic [15:0] a, input logic [31:0] d);
    wr_t w;
    w.a = a;
    w.d = d;
    if (sel_s) q_s.push_back(w);
    else q_m.push_back(w);
  endtask

  task automatic push_nominal();
    push_wr(1'b0, 16'h0000, 32'h12345678);
    push_wr(1'b0, 16'h0001, 32'h9ABCDEF0);
    push_wr(1'b1, 16'hFFFF, 32'h12345678);
    push_wr(1'b1, 16'h0000, 32'h9ABCDEF0);
  endtask

  // Called on a negedge; returns on the negedge after the byte's transfer edge
  task automatic send_stream(input int gap);
    foreach (stim[i]) begin
      int n;
      n = 0;
      in_data  = stim[i];
      in_valid = 1'b1;
      while (in_ready_m !== 1'b1 && n < 50) begin
        @(negedge clk);
        n++;
      end
      check("handshake_timeout", 32'(n < 50), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (gap) @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("rst_in_ready", 32'(in_ready_m), 32'd0);
    check("rst_im_we", 32'(im_we_m), 32'd0);
    check("rst_im_addr", 32'(im_addr_m), 32'h0000);
    check("rst_im_data", im_data_m, 32'd0);
    check("rst_cpu_rst_f", 32'(cpu_rst_f_m), 32'd0);
    check("rst_done", 32'(done_m), 32'd0);
    check("rst_err", 32'(err_m), 32'd0);
    check("rst_word_cnt", 32'(word_cnt_m), 32'd0);
    check("rst_s_im_addr", 32'(im_addr_s), 32'h0000FFFF);
    check("rst_s_im_we", 32'(im_we_s), 32'd0);
    q_m.delete();
    q_s.delete();
    nw_m = 0;
    nw_s = 0;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 32'(in_ready_m), 32'd1);
    check("post_rst_s_in_ready", 32'(in_ready_s), 32'd1);
  endtask

  task automatic fin_m(input string tag, input logic e_done, input logic e_err,
                       input logic [15:0] e_wc, input int e_nw);
    check({tag, "_done"}, 32'(done_m), 32'(e_done));
    check({tag, "_err"}, 32'(err_m), 32'(e_err));
    check({tag, "_cpu_rst_f"}, 32'(cpu_rst_f_m), 32'(e_done));
    check({tag, "_in_ready"}, 32'(in_ready_m), 32'd0);
    check({tag, "_word_cnt"}, 32'(word_cnt_m), 32'(e_wc));
    check({tag, "_writes"}, 32'(nw_m), 32'(e_nw));
    check({tag, "_pending"}, 32'(q_m.size()), 32'd0);
  endtask

  task automatic fin_s(input string tag, input logic e_done, input logic e_err,
                       input logic [15:0] e_wc, input int e_nw);
    check({tag, "_done"}, 32'(done_s), 32'(e_done));
    check({tag, "_err"}, 32'(err_s), 32'(e_err));
    check({tag, "_cpu_rst_f"}, 32'(cpu_rst_f_s), 32'(e_done));
    check({tag, "_in_ready"}, 32'(in_ready_s), 32'd0);
    check({tag, "_word_cnt"}, 32'(word_cnt_s), 32'(e_wc));
    check({tag, "_writes"}, 32'(nw_s), 32'(e_nw));
    check({tag, "_pending"}, 32'(q_s.size()), 32'd0);
  endtask

  initial begin
    // Nominal image, in_valid held high
    do_reset();
    push_nominal();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h02};
    send_stream(0);
    fin_m("nom", 1'b1, 1'b0, 16'd2, 2);
    fin_s("nom_s", 1'b1, 1'b0, 16'd2, 2);
    repeat (3) @(negedge clk);
    check("nom_done_sticky", 32'(done_m), 32'd1);

    // Bad checksum
    do_reset();
    push_nominal();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h03};
    send_stream(0);
    fin_m("badck", 1'b0, 1'b1, 16'd2, 2);
    fin_s("badck_s", 1'b0, 1'b1, 16'd2, 2);

    // Empty image
    do_reset();
    stim = '{8'h00, 8'h00, 8'h00};
    send_stream(0);
    fin_m("empty", 1'b1, 1'b0, 16'd0, 0);
    fin_s("empty_s", 1'b1, 1'b0, 16'd0, 0);

    // Throttled source: three idle cycles between bytes
    do_reset();
    push_nominal();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h02};
    send_stream(3);
    fin_m("thr", 1'b1, 1'b0, 16'd2, 2);
    fin_s("thr_s", 1'b1, 1'b0, 16'd2, 2);

    // Oversize count on the small instance; the default instance keeps accepting
    do_reset();
    stim = '{8'h00, 8'h05};
    send_stream(0);
    check("ovr_s_err", 32'(err_s), 32'd1);
    check("ovr_s_in_ready", 32'(in_ready_s), 32'd0);
    check("ovr_s_done", 32'(done_s), 32'd0);
    check("ovr_m_in_ready", 32'(in_ready_m), 32'd1);
    push_wr(1'b0, 16'h0000, 32'h11223344);
    stim = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    send_stream(0);
    check("ovr_s_writes", 32'(nw_s), 32'd0);
    check("ovr_s_err_sticky", 32'(err_s), 32'd1);
    check("ovr_s_word_cnt", 32'(word_cnt_s), 32'd0);
    check("ovr_s_cpu_rst_f", 32'(cpu_rst_f_s), 32'd0);
    check("ovr_m_writes", 32'(nw_m), 32'd1);
    check("ovr_m_word_cnt", 32'(word_cnt_m), 32'd1);
    check("ovr_m_pending", 32'(q_m.size()), 32'd0);

    // Reset mid-word, with the completing byte offered on the reset edge
    do_reset();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56};
    send_stream(0);
    check("mid_partial_writes", 32'(nw_m), 32'd0);
    in_data  = 8'h78;
    in_valid = 1'b1;
    do_reset();
    push_nominal();
    stim = '{8'h00, 8'h02, 8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC, 8'hDE, 8'hF0, 8'h02};
    send_stream(0);
    fin_m("mid", 1'b1, 1'b0, 16'd2, 2);
    fin_s("mid_s", 1'b1, 1'b0, 16'd2, 2);

    repeat (2) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
